// File: rtl/tqvp_xoshiro_fifo_if.sv
// tqvp_xoshiro_fifo_if: TinyQV peripheral bus between core (master) and peripheral (slave)
interface tqvp_xoshiro_fifo_if;
  logic [5:0] address;
  logic [31:0] data_in;
  logic [1:0] data_write_n;
  logic [1:0] data_read_n;
  logic [31:0] data_out;
  logic data_ready;
  modport master (output address, data_in, data_write_n, data_read_n, input data_out, data_ready);
  modport slave (input address, data_in, data_write_n, data_read_n, output data_out, data_ready);
endinterface

// File: rtl/tqvp_xoshiro_fifo.sv
// tqvp_xoshiro_fifo: xoshiro128++ random source with prefetch FIFO on the TinyQV peripheral bus
module tqvp_xoshiro_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter logic [31:0] SEED0 = 32'h1,
  parameter logic [31:0] SEED1 = 32'h2,
  parameter logic [31:0] SEED2 = 32'h3,
  parameter logic [31:0] SEED3 = 32'h4
) (
  input logic clk,
  input logic rst_n,
  input logic [7:0] ui_in,
  output logic [7:0] uo_out,
  output logic user_interrupt,
  tqvp_xoshiro_fifo_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [31:0] s_q [4];
  logic [31:0] s_d [4];
  logic [31:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [4:0] level_q;
  logic [7:0] ctrl_q;
  logic irq_q;
  logic [31:0] sum, rnd_w, x2, x3, n0, n1, n2, n3;
  logic rd, wr, rnd_rd, seed_wr, ctrl_wr, empty, full, pop, push;
  logic [1:0] seed_idx;
  logic unused_ok;
  assign unused_ok = &{1'b0, ui_in};
  assign sum = s_q[0] + s_q[3];
  assign rnd_w = {sum[24:0], sum[31:25]} + s_q[0];
  assign x2 = s_q[2] ^ s_q[0];
  assign x3 = s_q[3] ^ s_q[1];
  assign n1 = s_q[1] ^ x2;
  assign n0 = s_q[0] ^ x3;
  assign n2 = x2 ^ (s_q[1] << 9);
  assign n3 = {x3[20:0], x3[31:21]};
  assign rd = bus.data_read_n != 2'b11;
  assign wr = bus.data_write_n != 2'b11;
  assign rnd_rd = rd && bus.address == 6'h00;
  assign seed_wr = bus.data_write_n == 2'b10 && bus.address inside {6'h04, 6'h08, 6'h0C, 6'h10};
  assign seed_idx = 2'(bus.address[4:2] - 3'd1);
  assign ctrl_wr = wr && bus.address == 6'h14;
  assign empty = level_q == 5'd0;
  assign full = level_q == 5'(FIFO_DEPTH);
  assign pop = rst_n && rnd_rd && !empty;
  assign push = rst_n && ctrl_q[0] && (!full || pop) && !seed_wr;
  always_comb begin
    s_d[0] = (seed_wr && seed_idx == 2'd0) ? bus.data_in : push ? n0 : s_q[0];
    s_d[1] = (seed_wr && seed_idx == 2'd1) ? bus.data_in : push ? n1 : s_q[1];
    s_d[2] = (seed_wr && seed_idx == 2'd2) ? bus.data_in : push ? n2 : s_q[2];
    s_d[3] = (seed_wr && seed_idx == 2'd3) ? bus.data_in : push ? n3 : s_q[3];
    if (seed_wr && ~|(s_d[0] | s_d[1] | s_d[2] | s_d[3])) s_d[0] = 32'h1;
  end
  always_ff @(posedge clk)
    if (push) mem_q[wp_q] <= rnd_w;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q[0] <= SEED0;
      s_q[1] <= SEED1;
      s_q[2] <= SEED2;
      s_q[3] <= SEED3;
      wp_q <= '0;
      rp_q <= '0;
      level_q <= '0;
      ctrl_q <= 8'h01;
      irq_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) s_q[i] <= s_d[i];
      if (seed_wr) begin
        wp_q <= '0;
        rp_q <= '0;
        level_q <= '0;
      end else begin
        if (push) wp_q <= wp_q + AW'(1);
        if (pop) rp_q <= rp_q + AW'(1);
        level_q <= level_q + 5'(push) - 5'(pop);
      end
      if (ctrl_wr) ctrl_q <= bus.data_in[7:0] & 8'hF3;
      irq_q <= ctrl_q[1] && level_q >= {1'b0, ctrl_q[7:4]};
    end
  end
  assign bus.data_ready = rst_n && (rnd_rd ? !empty : (rd || wr));
  assign bus.data_out = !rst_n ? '0 :
                        bus.address == 6'h00 ? mem_q[rp_q] :
                        bus.address == 6'h14 ? {24'h0, ctrl_q} :
                        bus.address == 6'h18 ? {22'h0, full, empty, 3'h0, level_q} : '0;
  assign uo_out = 8'h00;
  assign user_interrupt = irq_q;
endmodule

// File: tb/tb_tqvp_xoshiro_fifo.sv
// tb_tqvp_xoshiro_fifo: directed scoreboard bench for the xoshiro128++ FIFO peripheral
module tb_tqvp_xoshiro_fifo;
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_out;
  logic user_interrupt;
  int checks = 0;
  int failures = 0;
  logic [31:0] m [4];
  logic [31:0] sb [$];
  tqvp_xoshiro_fifo_if bus ();
  tqvp_xoshiro_fifo dut (
    .clk(clk),
    .rst_n(rst_n),
    .ui_in(ui_in),
    .uo_out(uo_out),
    .user_interrupt(user_interrupt),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_seed(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
    m[0] = (a | b | c | d) == 32'h0 ? 32'h1 : a;
    m[1] = b;
    m[2] = c;
    m[3] = d;
  endtask
  task automatic model_next(output logic [31:0] r);
    logic [31:0] s, t;
    s = m[0] + m[3];
    r = ((s << 7) | (s >> 25)) + m[0];
    t = m[1] << 9;
    m[2] = m[2] ^ m[0];
    m[3] = m[3] ^ m[1];
    m[1] = m[1] ^ m[2];
    m[0] = m[0] ^ m[3];
    m[2] = m[2] ^ t;
    m[3] = (m[3] << 11) | (m[3] >> 21);
  endtask
  task automatic rd(input logic [5:0] a, input logic [1:0] w, output logic [31:0] d, output logic got);
    bus.address = a;
    bus.data_read_n = w;
    got = 1'b0;
    d = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.data_ready) begin
        got = 1'b1;
        d = bus.data_out;
      end
    end
    @(posedge clk);
    #1;
    bus.data_read_n = 2'b11;
  endtask
  task automatic wr(input logic [5:0] a, input logic [1:0] w, input logic [31:0] d);
    bus.address = a;
    bus.data_write_n = w;
    bus.data_in = d;
    @(negedge clk);
    chk("wr_ready", 32'(bus.data_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.data_write_n = 2'b11;
  endtask
  task automatic reg_rd(input string tag, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic got;
    rd(a, 2'b10, d, got);
    chk({tag, "_ready"}, 32'(got), 32'd1);
    chk(tag, d, exp);
  endtask
  task automatic rnd(input string tag, input logic [1:0] w, input bit lit, input logic [31:0] lv);
    logic [31:0] mw, d, e;
    logic got;
    model_next(mw);
    sb.push_back(lit ? lv : mw);
    rd(6'h00, w, d, got);
    chk({tag, "_ready"}, 32'(got), 32'd1);
    if (got) begin
      e = sb.pop_front();
      chk(tag, d, e);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    logic seen;
    rst_n = 1'b0;
    bus.address = 6'h00;
    bus.data_in = '0;
    bus.data_write_n = 2'b11;
    bus.data_read_n = 2'b10;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.data_ready), 32'd0);
    chk("rst_data_out", bus.data_out, 32'd0);
    chk("rst_irq", 32'(user_interrupt), 32'd0);
    chk("rst_uo_out", 32'(uo_out), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.data_read_n = 2'b11;
    model_seed(32'h1, 32'h2, 32'h3, 32'h4);
    rnd("rnd_first", 2'b10, 1'b1, 32'h0000_0281);
    rnd("rnd_second", 2'b10, 1'b1, 32'h0018_0387);
    repeat (10) @(posedge clk);
    #1;
    reg_rd("status_full", 6'h18, 32'h0000_0204);
    rnd("rnd_refill", 2'b10, 1'b0, '0);
    reg_rd("status_refilled", 6'h18, 32'h0000_0204);
    reg_rd("ctrl_reset", 6'h14, 32'h0000_0001);
    wr(6'h14, 2'b10, 32'h0);
    for (int i = 0; i < 4; i++) rnd("rnd_drain", 2'b10, 1'b0, '0);
    bus.address = 6'h00;
    bus.data_read_n = 2'b10;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen |= bus.data_ready;
    end
    chk("stall_empty", 32'(seen), 32'd0);
    @(posedge clk);
    #1;
    bus.data_read_n = 2'b11;
    reg_rd("status_empty", 6'h18, 32'h0000_0100);
    wr(6'h14, 2'b10, 32'h1);
    rnd("rnd_resume", 2'b10, 1'b0, '0);
    repeat (6) @(posedge clk);
    #1;
    reg_rd("status_pre_b2b", 6'h18, 32'h0000_0204);
    for (int i = 0; i < 20; i++) rnd("rnd_b2b", (i % 3 == 0) ? 2'b00 : (i % 3 == 1) ? 2'b01 : 2'b10, 1'b0, '0);
    reg_rd("status_post_b2b", 6'h18, 32'h0000_0204);
    wr(6'h04, 2'b10, 32'h1);
    wr(6'h08, 2'b10, 32'h2);
    wr(6'h0C, 2'b10, 32'h3);
    wr(6'h10, 2'b10, 32'h4);
    reg_rd("status_flushed", 6'h18, 32'h0000_0100);
    model_seed(32'h1, 32'h2, 32'h3, 32'h4);
    rnd("rnd_reseed", 2'b10, 1'b1, 32'h0000_0281);
    repeat (6) @(posedge clk);
    #1;
    wr(6'h04, 2'b01, 32'h0);
    reg_rd("status_half_seed", 6'h18, 32'h0000_0204);
    rnd("rnd_half_seed", 2'b10, 1'b0, '0);
    wr(6'h04, 2'b10, 32'h0);
    wr(6'h08, 2'b10, 32'h0);
    wr(6'h0C, 2'b10, 32'h0);
    wr(6'h10, 2'b10, 32'h0);
    model_seed(32'h0, 32'h0, 32'h0, 32'h0);
    rnd("rnd_zero_seed", 2'b10, 1'b1, 32'h0000_0081);
    rnd("rnd_zero_seed2", 2'b10, 1'b0, '0);
    wr(6'h14, 2'b10, 32'h33);
    repeat (6) @(posedge clk);
    #1;
    wr(6'h14, 2'b10, 32'h32);
    @(negedge clk);
    chk("irq_full", 32'(user_interrupt), 32'd1);
    @(posedge clk);
    #1;
    rnd("rnd_irq1", 2'b10, 1'b0, '0);
    rnd("rnd_irq2", 2'b10, 1'b0, '0);
    @(negedge clk);
    chk("irq_lag", 32'(user_interrupt), 32'd1);
    @(negedge clk);
    chk("irq_drop", 32'(user_interrupt), 32'd0);
    @(posedge clk);
    #1;
    wr(6'h14, 2'b00, 32'hFFFF_FFFF);
    reg_rd("ctrl_byte", 6'h14, 32'h0000_00F3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("irq_thresh15", 32'(user_interrupt), 32'd0);
    @(posedge clk);
    #1;
    wr(6'h14, 2'b10, 32'h2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("irq_thresh0", 32'(user_interrupt), 32'd1);
    @(posedge clk);
    #1;
    wr(6'h1C, 2'b10, 32'hDEAD_BEEF);
    reg_rd("unmapped", 6'h1C, 32'h0);
    reg_rd("seed_wo", 6'h04, 32'h0);
    chk("uo_out", 32'(uo_out), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
